// File: rtl/axi_mem_if.sv
// AW/W/B/AR/R bundle between the core's memory masters and the backing memory.
// The master drives requests and write data; the slave drives readies and responses.
interface axi_mem_if #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
);
    logic                  AWVALID;
    logic                  AWREADY;
    logic [3:0]            AWID;
    logic [3:0]            AWLEN;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  WVALID;
    logic                  WREADY;
    logic                  WLAST;
    logic [3:0]            WID;
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  BVALID;
    logic                  BREADY;
    logic [3:0]            BID;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [3:0]            ARID;
    logic [3:0]            ARLEN;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  RVALID;
    logic                  RREADY;
    logic                  RLAST;
    logic [3:0]            RID;
    logic [DATA_WIDTH-1:0] RDATA;

    modport master (
        output AWVALID, AWID, AWLEN, AWADDR,
        output WVALID, WLAST, WID, WDATA,
        output BREADY,
        output ARVALID, ARID, ARLEN, ARADDR,
        output RREADY,
        input  AWREADY, WREADY, BVALID, BID,
        input  ARREADY, RVALID, RLAST, RID, RDATA
    );

    modport slave (
        input  AWVALID, AWID, AWLEN, AWADDR,
        input  WVALID, WLAST, WID, WDATA,
        input  BREADY,
        input  ARVALID, ARID, ARLEN, ARADDR,
        input  RREADY,
        output AWREADY, WREADY, BVALID, BID,
        output ARREADY, RVALID, RLAST, RID, RDATA
    );
endinterface

// File: rtl/axi_mem_responder.sv
// Word-addressed backing memory answering one write and one read burst at a time.
// Read and write engines run concurrently; INCR bursts wrap at the top of the array.
module axi_mem_responder #(
    parameter int ADDR_WIDTH     = 26,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DEPTH_LOG2 = 14,
    parameter int READ_LATENCY   = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    axi_mem_if.slave bus,
    output logic     err
);
    localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT =
        (READ_LATENCY > 0) ? LAT_W'(READ_LATENCY - 1) : '0;

    typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LAT, R_BURST} r_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    w_state_t   w_state;
    logic [3:0] w_id;
    logic [3:0] w_len;
    logic [3:0] w_beat;
    idx_t       w_idx;
    idx_t       w_addr;
    logic       w_fire;

    r_state_t   r_state;
    logic [3:0] r_id;
    logic [3:0] r_len;
    logic [3:0] r_beat;
    logic [3:0] r_beat_nxt;
    idx_t       r_idx;
    idx_t       r_addr_nxt;
    logic [LAT_W-1:0] lat_cnt;

    // Byte lane bits and address bits above the array are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.AWADDR, bus.ARADDR};

    assign w_fire     = (w_state == W_DATA) && bus.WVALID;
    assign w_addr     = w_idx + idx_t'(w_beat);
    assign r_beat_nxt = r_beat + 4'd1;
    assign r_addr_nxt = r_idx + idx_t'(r_beat_nxt);

    // Array is never reset; a read loaded on the same edge sees the old word.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            mem[w_addr] <= bus.WDATA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state     <= W_IDLE;
            bus.AWREADY <= 1'b1;
            bus.WREADY  <= 1'b0;
            bus.BVALID  <= 1'b0;
            bus.BID     <= '0;
            w_id        <= '0;
            w_len       <= '0;
            w_beat      <= '0;
            w_idx       <= '0;
            err         <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (bus.AWVALID) begin
                        w_id        <= bus.AWID;
                        w_len       <= bus.AWLEN;
                        w_idx       <= bus.AWADDR[MEM_DEPTH_LOG2+1:2];
                        w_beat      <= '0;
                        bus.AWREADY <= 1'b0;
                        bus.WREADY  <= 1'b1;
                        w_state     <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (bus.WVALID) begin
                        // Mismatched WLAST or WID is flagged but never shortens the burst.
                        if ((bus.WLAST != (w_beat == w_len)) || (bus.WID != w_id)) begin
                            err <= 1'b1;
                        end
                        if (w_beat == w_len) begin
                            bus.WREADY <= 1'b0;
                            bus.BVALID <= 1'b1;
                            bus.BID    <= w_id;
                            w_state    <= W_RESP;
                        end else begin
                            w_beat <= w_beat + 4'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.BREADY) begin
                        bus.BVALID  <= 1'b0;
                        bus.AWREADY <= 1'b1;
                        w_state     <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= R_IDLE;
            bus.ARREADY <= 1'b1;
            bus.RVALID  <= 1'b0;
            bus.RLAST   <= 1'b0;
            bus.RID     <= '0;
            bus.RDATA   <= '0;
            r_id        <= '0;
            r_len       <= '0;
            r_beat      <= '0;
            r_idx       <= '0;
            lat_cnt     <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (bus.ARVALID) begin
                        r_id        <= bus.ARID;
                        r_len       <= bus.ARLEN;
                        r_idx       <= bus.ARADDR[MEM_DEPTH_LOG2+1:2];
                        r_beat      <= '0;
                        lat_cnt     <= LAT_INIT;
                        bus.ARREADY <= 1'b0;
                        r_state     <= (READ_LATENCY == 0) ? R_BURST : R_LAT;
                    end
                end
                R_LAT: begin
                    if (lat_cnt == '0) begin
                        r_state <= R_BURST;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                R_BURST: begin
                    // First cycle in R_BURST loads beat 0; afterwards each handshake loads the next.
                    if (!bus.RVALID) begin
                        bus.RVALID <= 1'b1;
                        bus.RDATA  <= mem[r_idx];
                        bus.RID    <= r_id;
                        bus.RLAST  <= (r_len == 4'd0);
                    end else if (bus.RREADY) begin
                        if (bus.RLAST) begin
                            bus.RVALID  <= 1'b0;
                            bus.RLAST   <= 1'b0;
                            bus.ARREADY <= 1'b1;
                            r_state     <= R_IDLE;
                        end else begin
                            r_beat    <= r_beat_nxt;
                            bus.RDATA <= mem[r_addr_nxt];
                            bus.RLAST <= (r_beat_nxt == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder on a 16-word array with 4-cycle read latency.
module tb_axi_mem_responder;
    logic clk = 1'b0;
    logic rst_n;
    logic err;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef logic [31:0] word_arr_t [16];

    localparam logic [31:0] VA = 32'hA0A0_0001;
    localparam logic [31:0] VB = 32'hB0B0_0002;
    localparam logic [31:0] VC = 32'hC0C0_0003;
    localparam logic [31:0] VD = 32'hD0D0_0004;

    axi_mem_if #(.ADDR_WIDTH(26), .DATA_WIDTH(32)) bus ();

    axi_mem_responder #(
        .ADDR_WIDTH(26),
        .DATA_WIDTH(32),
        .MEM_DEPTH_LOG2(4),
        .READ_LATENCY(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expd);
        n_checks++;
        assert (obs === expd) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
        end
    endtask

    task automatic write_burst(input logic [25:0] addr, input logic [3:0] len, input logic [3:0] id,
                               input logic [3:0] wid, input word_arr_t data, input int wlast_beat,
                               input int bdelay);
        check("awready_idle", bus.AWREADY, 1);
        bus.AWVALID = 1'b1;
        bus.AWADDR  = addr;
        bus.AWID    = id;
        bus.AWLEN   = len;
        bus.BREADY  = 1'b0;
        @(negedge clk);
        bus.AWVALID = 1'b0;
        check("awready_busy", bus.AWREADY, 0);
        for (int k = 0; k <= int'(len); k++) begin
            check("wready_beat", bus.WREADY, 1);
            bus.WVALID = 1'b1;
            bus.WDATA  = data[k];
            bus.WLAST  = (k == wlast_beat);
            bus.WID    = wid;
            @(negedge clk);
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        check("wready_off", bus.WREADY, 0);
        check("bvalid_on", bus.BVALID, 1);
        check("bid", bus.BID, id);
        for (int i = 0; i < bdelay; i++) begin
            @(negedge clk);
            check("bvalid_hold", bus.BVALID, 1);
            check("awready_resp", bus.AWREADY, 0);
        end
        bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
        check("bvalid_done", bus.BVALID, 0);
        check("awready_back", bus.AWREADY, 1);
    endtask

    task automatic read_burst(input logic [25:0] addr, input logic [3:0] len, input logic [3:0] id,
                              input word_arr_t expd, input bit bp);
        int cnt;
        int guard;
        int beat;
        bit rr;
        check("arready_idle", bus.ARREADY, 1);
        bus.ARVALID = 1'b1;
        bus.ARADDR  = addr;
        bus.ARID    = id;
        bus.ARLEN   = len;
        bus.RREADY  = !bp;
        @(negedge clk);
        bus.ARVALID = 1'b0;
        cnt = 0;
        while (!bus.RVALID && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("first_rvalid_latency", cnt, 5);
        beat  = 0;
        guard = 0;
        while (beat <= int'(len) && guard < 100) begin
            check("rvalid", bus.RVALID, 1);
            check("rdata", bus.RDATA, expd[beat]);
            check("rlast", bus.RLAST, beat == int'(len));
            check("rid", bus.RID, id);
            check("arready_busy", bus.ARREADY, 0);
            rr = bp ? (guard % 3 == 0) : 1'b1;
            bus.RREADY = rr;
            @(negedge clk);
            if (rr) beat++;
            guard++;
        end
        bus.RREADY = 1'b0;
        check("beats_done", beat, int'(len) + 1);
        check("rvalid_end", bus.RVALID, 0);
        check("rlast_end", bus.RLAST, 0);
        check("arready_end", bus.ARREADY, 1);
    endtask

    initial begin
        word_arr_t dw;
        word_arr_t dr;
        int cnt;

        rst_n       = 1'b0;
        bus.AWVALID = 1'b0; bus.AWID = '0; bus.AWLEN = '0; bus.AWADDR = '0;
        bus.WVALID  = 1'b0; bus.WLAST = 1'b0; bus.WID = '0; bus.WDATA = '0;
        bus.BREADY  = 1'b0;
        bus.ARVALID = 1'b0; bus.ARID = '0; bus.ARLEN = '0; bus.ARADDR = '0;
        bus.RREADY  = 1'b0;
        dw = '{default: '0};
        dr = '{default: '0};

        #12;
        check("rst_awready", bus.AWREADY, 1);
        check("rst_arready", bus.ARREADY, 1);
        check("rst_wready", bus.WREADY, 0);
        check("rst_bvalid", bus.BVALID, 0);
        check("rst_rvalid", bus.RVALID, 0);
        check("rst_rlast", bus.RLAST, 0);
        check("rst_bid", bus.BID, 0);
        check("rst_rid", bus.RID, 0);
        check("rst_rdata", bus.RDATA, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write then single read of the same word
        dw[0] = 32'hDEAD_BEEF;
        write_burst(26'h100, 4'd0, 4'd3, 4'd3, dw, 0, 0);
        dr[0] = 32'hDEAD_BEEF;
        read_burst(26'h100, 4'd0, 4'd3, dr, 1'b0);

        // Preload the whole array with its index, then full-length reads
        for (int i = 0; i < 16; i++) dw[i] = 32'(i);
        write_burst(26'h100, 4'd15, 4'd1, 4'd1, dw, 15, 0);
        for (int i = 0; i < 16; i++) dr[i] = 32'(i);
        read_burst(26'h100, 4'd15, 4'd2, dr, 1'b0);
        read_burst(26'h100, 4'd15, 4'd2, dr, 1'b1);

        // Wrap at the top of the array: words 14, 15, 0, 1
        dw[0] = VA; dw[1] = VB; dw[2] = VC; dw[3] = VD;
        write_burst(26'h38, 4'd3, 4'd6, 4'd6, dw, 3, 0);
        check("wrap_err", err, 0);
        dr[0] = VA; dr[1] = VB; dr[2] = VC; dr[3] = VD;
        read_burst(26'h38, 4'd3, 4'd7, dr, 1'b0);
        dr[0] = VC; dr[1] = VD;
        read_burst(26'h0, 4'd1, 4'd7, dr, 1'b0);

        // Early WLAST: still four beats, sticky err
        for (int i = 0; i < 4; i++) dw[i] = 32'h4444_0000 + 32'(i);
        write_burst(26'h10, 4'd3, 4'd9, 4'd9, dw, 2, 0);
        check("wlast_err_set", err, 1);
        for (int i = 0; i < 4; i++) dr[i] = 32'h4444_0000 + 32'(i);
        read_burst(26'h10, 4'd3, 4'd9, dr, 1'b0);
        check("wlast_err_sticky", err, 1);

        // Overlapping write (words 8..11, BREADY late) and read (words 12..15)
        for (int i = 0; i < 4; i++) dw[i] = 32'h8888_0000 + 32'(i);
        dr[0] = 32'd12; dr[1] = 32'd13; dr[2] = VA; dr[3] = VB;
        fork
            write_burst(26'h20, 4'd3, 4'd5, 4'd5, dw, 3, 3);
            read_burst(26'h30, 4'd3, 4'd4, dr, 1'b0);
        join
        for (int i = 0; i < 4; i++) dr[i] = 32'h8888_0000 + 32'(i);
        read_burst(26'h20, 4'd3, 4'd5, dr, 1'b0);
        check("concurrent_err_sticky", err, 1);

        // Asynchronous reset in the middle of a read burst
        bus.ARVALID = 1'b1; bus.ARADDR = 26'h100; bus.ARID = 4'd2; bus.ARLEN = 4'd15;
        bus.RREADY  = 1'b1;
        @(negedge clk);
        bus.ARVALID = 1'b0;
        cnt = 0;
        while (!bus.RVALID && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("rst_read_started", bus.RVALID, 1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rvalid", bus.RVALID, 0);
        check("midrst_rlast", bus.RLAST, 0);
        check("midrst_arready", bus.ARREADY, 1);
        check("midrst_awready", bus.AWREADY, 1);
        check("midrst_rdata", bus.RDATA, 0);
        check("midrst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_rvalid", bus.RVALID, 0);
            check("postrst_rlast", bus.RLAST, 0);
        end
        bus.RREADY = 1'b0;

        // Array contents survive reset
        dr[0] = VC; dr[1] = VD;
        read_burst(26'h0, 4'd1, 4'd1, dr, 1'b0);

        // WID differing from AWID flags err
        check("wid_err_clear", err, 0);
        dw[0] = 32'h1234_5678;
        write_burst(26'h4, 4'd0, 4'd3, 4'd14, dw, 0, 0);
        check("wid_err_set", err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
